// File: rtl/ta_pkg.sv
// Shared definitions for the Tsetlin automaton bank: feedback codes,
// sequencer state encoding and the action-flip counter width.
package ta_pkg;

    // Per-automaton feedback codes; 2'b11 is reserved and behaves like FB_NONE.
    localparam logic [1:0] FB_NONE     = 2'b00;
    localparam logic [1:0] FB_REWARD   = 2'b01;
    localparam logic [1:0] FB_PENALTY  = 2'b10;
    localparam logic [1:0] FB_RESERVED = 2'b11;

    // Width of the saturating action-flip counter.
    localparam int FLIP_CNT_W = 16;

    // Update sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } bank_state_e;

endpackage

// File: rtl/ta_update.sv
// Combinational next-state logic for a single Tsetlin automaton.
// The upper half of the state range selects the action, the lower half rejects it.
// Reward pushes the state deeper into its current half (saturating at the
// ends); penalty pushes it toward the centre and never saturates.
module ta_update
    import ta_pkg::*;
#(
    parameter int STATE_BITS = 4
) (
    input  logic [STATE_BITS-1:0] state,
    input  logic [1:0]            code,
    output logic [STATE_BITS-1:0] next_state,
    output logic                  flip
);

    localparam logic [STATE_BITS-1:0] STATE_MAX = {STATE_BITS{1'b1}};
    localparam logic [STATE_BITS-1:0] STATE_MIN = '0;

    // Apply one feedback code to one automaton state.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        next_state = state;
        case (code)
            FB_REWARD: begin
                if (state[STATE_BITS-1]) begin
                    if (state != STATE_MAX) next_state = state + 1'b1;
                end else begin
                    if (state != STATE_MIN) next_state = state - 1'b1;
                end
            end
            FB_PENALTY: begin
                if (state[STATE_BITS-1]) next_state = state - 1'b1;
                else                     next_state = state + 1'b1;
            end
            default: next_state = state;
        endcase
    end

    // The action is the MSB, so a flip is any change of that bit.
    assign flip = next_state[STATE_BITS-1] ^ state[STATE_BITS-1];

endmodule

// File: rtl/ta_bank.sv
// Bank of NUM_TA Tsetlin automata updated one per cycle from a captured
// feedback vector. A single ta_update instance is time-shared via the index.
// Optional feature: define TA_BANK_FLIPCNT_EN to enable the saturating
// action-flip counter on flip_count; otherwise flip_count is tied to zero.
module ta_bank
    import ta_pkg::*;
#(
    parameter int NUM_TA     = 4,
    parameter int STATE_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fb_valid,
    output logic                    fb_ready,
    input  logic [2*NUM_TA-1:0]     fb_code,
    output logic [NUM_TA-1:0]       incl,
    output logic                    busy,
    output logic                    done,
    output logic [FLIP_CNT_W-1:0]   flip_count
);

    localparam int IDX_W = (NUM_TA > 1) ? $clog2(NUM_TA) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TA - 1);
    // Weak exclude: just below the midpoint.
    localparam logic [STATE_BITS-1:0] RESET_STATE = {1'b0, {(STATE_BITS-1){1'b1}}};

    bank_state_e               fsm_q, fsm_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [2*NUM_TA-1:0]       code_q, code_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [STATE_BITS-1:0]     ta_state_q [NUM_TA];
    logic [STATE_BITS-1:0]     ta_state_d [NUM_TA];

    logic [STATE_BITS-1:0]     cur_state;
    logic [STATE_BITS-1:0]     upd_state;
    logic [1:0]                cur_code;
    logic                      upd_flip;
    logic                      accept;

    assign accept    = ready_q & fb_valid;
    assign cur_state = ta_state_q[idx_q];
    assign cur_code  = code_q[{idx_q, 1'b0} +: 2];

    ta_update #(
        .STATE_BITS (STATE_BITS)
    ) u_update (
        .state      (cur_state),
        .code       (cur_code),
        .next_state (upd_state),
        .flip       (upd_flip)
    );

    // Sequencer next state, captured feedback, index and per-state output flags.
    always_comb begin
        fsm_d  = fsm_q;
        code_d = code_q;
        idx_d  = idx_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d = fb_code;
                    idx_d  = '0;
                    fsm_d  = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    fsm_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE:  fsm_d = ST_IDLE;
            default:  fsm_d = ST_IDLE;
        endcase
        // Outputs are registered versions of the state being entered.
        ready_d = (fsm_d == ST_IDLE);
        busy_d  = (fsm_d == ST_UPDATE);
        done_d  = (fsm_d == ST_DONE);
    end

    // Write back the shared updater result to the automaton under the index.
    always_comb begin
        for (int i = 0; i < NUM_TA; i++) ta_state_d[i] = ta_state_q[i];
        if (fsm_q == ST_UPDATE) ta_state_d[idx_q] = upd_state;
    end

    // Sequencer, output flags and automaton state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            code_q  <= '0;
            idx_q   <= '0;
            // NOTE: the state array is reset on purpose -- a reset must discard any half-applied update.
            for (int i = 0; i < NUM_TA; i++) ta_state_q[i] <= RESET_STATE;
        end else begin
            fsm_q   <= fsm_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM_TA; i++) ta_state_q[i] <= ta_state_d[i];
        end
    end

    // The action of each automaton is the MSB of its state.
    always_comb begin
        for (int i = 0; i < NUM_TA; i++) incl[i] = ta_state_q[i][STATE_BITS-1];
    end

    assign fb_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef TA_BANK_FLIPCNT_EN
    logic [FLIP_CNT_W-1:0] flip_cnt_q, flip_cnt_d;

    // Count processed automata whose action changed, saturating at all-ones.
    always_comb begin
        flip_cnt_d = flip_cnt_q;
        if ((fsm_q == ST_UPDATE) && upd_flip && (flip_cnt_q != {FLIP_CNT_W{1'b1}}))
            flip_cnt_d = flip_cnt_q + 1'b1;
    end

    // Flip counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flip_cnt_q <= '0;
        else        flip_cnt_q <= flip_cnt_d;
    end

    assign flip_count = flip_cnt_q;
`else
    logic unused_flip;
    assign unused_flip = upd_flip;
    assign flip_count  = '0;
`endif

endmodule

// File: tb/tb_ta_bank.sv
// Self-checking bench for ta_bank (NUM_TA=4, STATE_BITS=4). Expected values
// come from an integer reference model of the automaton rules.
module tb_ta_bank;

    localparam int NUM_TA = 4;
    localparam int SB     = 4;
    localparam int MID    = 8;
    localparam int SMAX   = 15;
    localparam int RST_ST = 7;
`ifdef TA_BANK_FLIPCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 fb_valid = 1'b0;
    logic [2*NUM_TA-1:0]  fb_code = '0;
    logic                 fb_ready;
    logic [NUM_TA-1:0]    incl;
    logic                 busy;
    logic                 done;
    logic [15:0]          flip_count;

    int total = 0;
    int bad   = 0;
    int m_state [NUM_TA];
    int m_flips;

    ta_bank #(.NUM_TA(NUM_TA), .STATE_BITS(SB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .fb_code    (fb_code),
        .incl       (incl),
        .busy       (busy),
        .done       (done),
        .flip_count (flip_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ta_next(input int s, input logic [1:0] c);
        if (c == 2'b01) begin
            if (s >= MID) return (s == SMAX) ? s : s + 1;
            else          return (s == 0) ? 0 : s - 1;
        end else if (c == 2'b10) begin
            return (s >= MID) ? s - 1 : s + 1;
        end
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_TA; i++) m_state[i] = RST_ST;
        m_flips = 0;
    endfunction

    function automatic void model_apply(input logic [2*NUM_TA-1:0] code);
        int ns;
        for (int i = 0; i < NUM_TA; i++) begin
            ns = ta_next(m_state[i], code[2*i +: 2]);
            if (CNT_EN && ((ns >= MID) != (m_state[i] >= MID)) && m_flips < 65535) m_flips++;
            m_state[i] = ns;
        end
    endfunction

    function automatic logic [NUM_TA-1:0] model_incl();
        logic [NUM_TA-1:0] v;
        for (int i = 0; i < NUM_TA; i++) v[i] = (m_state[i] >= MID);
        return v;
    endfunction

    // Offer one vector, then report the cycle (after acceptance) of the done pulse.
    task automatic run_txn(input logic [2*NUM_TA-1:0] code, output int done_at);
        int w;
        done_at = -1;
        w = 0;
        while (fb_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        fb_valid = 1'b1;
        fb_code  = code;
        @(negedge clk);
        fb_valid = 1'b0;
        fb_code  = 8'($urandom);
        model_apply(code);
        for (int c = 1; c <= 12; c++) begin
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (fb_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", fb_ready); end
        total++; if (incl !== 4'b0000) begin bad++; $display("FAIL rst_incl: got %b expected 0000", incl); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done: got %b%b expected 00", busy, done); end
        total++; if (flip_count !== 16'd0) begin bad++; $display("FAIL rst_flip: got %0d expected 0", flip_count); end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        total++; if (fb_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b expected 1", fb_ready); end
        for (int i = 0; i < NUM_TA; i++) begin
            total++;
            if (int'(dut.ta_state_q[i]) !== RST_ST) begin bad++; $display("FAIL rst_state%0d: got %0d expected %0d", i, dut.ta_state_q[i], RST_ST); end
        end
    endtask

    task automatic test_all_penalty();
        int snap [NUM_TA];
        logic [NUM_TA-1:0] exp_inc;
        for (int i = 0; i < NUM_TA; i++) snap[i] = m_state[i];
        fb_valid = 1'b1;
        fb_code  = 8'hAA;
        @(negedge clk);
        fb_valid = 1'b0;
        fb_code  = 8'h55;
        for (int c = 1; c <= 5; c++) begin
            for (int i = 0; i < NUM_TA; i++)
                exp_inc[i] = ((i < c - 1) ? ta_next(snap[i], 2'b10) : snap[i]) >= MID;
            total++; if (incl !== exp_inc) begin bad++; $display("FAIL pen_incl_c%0d: got %b expected %b", c, incl, exp_inc); end
            total++; if (busy !== (c <= 4)) begin bad++; $display("FAIL pen_busy_c%0d: got %b expected %b", c, busy, c <= 4); end
            total++; if (done !== (c == 5)) begin bad++; $display("FAIL pen_done_c%0d: got %b expected %b", c, done, c == 5); end
            total++; if (fb_ready !== 1'b0) begin bad++; $display("FAIL pen_ready_c%0d: got %b expected 0", c, fb_ready); end
            @(negedge clk);
        end
        total++; if (fb_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL pen_back_idle: got ready=%b done=%b expected 1 0", fb_ready, done); end
        model_apply(8'hAA);
        for (int i = 0; i < NUM_TA; i++) begin
            total++;
            if (int'(dut.ta_state_q[i]) !== m_state[i]) begin bad++; $display("FAIL pen_state%0d: got %0d expected %0d", i, dut.ta_state_q[i], m_state[i]); end
        end
        total++; if (flip_count !== 16'(m_flips)) begin bad++; $display("FAIL pen_flip: got %0d expected %0d", flip_count, m_flips); end
    endtask

    task automatic test_saturation();
        int d;
        int late;
        late = 0;
        run_txn(8'b0000_1001, d);
        if (d != 5) late++;
        for (int k = 0; k < 7; k++) begin
            run_txn(8'b0000_0101, d);
            if (d != 5) late++;
        end
        total++; if (late !== 0) begin bad++; $display("FAIL sat_done_timing: got %0d late transactions expected 0", late); end
        // Both boundary automata now sit at their rails; one more reward must hold them.
        run_txn(8'b0000_0101, d);
        total++; if (int'(dut.ta_state_q[0]) !== SMAX) begin bad++; $display("FAIL sat_ta0: got %0d expected %0d", dut.ta_state_q[0], SMAX); end
        total++; if (int'(dut.ta_state_q[1]) !== 0) begin bad++; $display("FAIL sat_ta1: got %0d expected 0", dut.ta_state_q[1]); end
        total++; if (incl !== model_incl()) begin bad++; $display("FAIL sat_incl: got %b expected %b", incl, model_incl()); end
        total++; if (flip_count !== 16'(m_flips)) begin bad++; $display("FAIL sat_flip: got %0d expected %0d", flip_count, m_flips); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [$];
        logic [7:0] acc_code [$];
        int w;
        fb_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            fb_code = 8'($urandom);
            if (fb_ready === 1'b1) begin
                acc_cyc.push_back(c);
                acc_code.push_back(fb_code);
            end
            @(negedge clk);
        end
        fb_valid = 1'b0;
        w = 0;
        while (fb_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++; if (acc_cyc.size() !== 4) begin bad++; $display("FAIL b2b_count: got %0d expected 4", acc_cyc.size()); end
        for (int k = 1; k < acc_cyc.size(); k++) begin
            total++;
            if (acc_cyc[k] - acc_cyc[k-1] !== 6) begin bad++; $display("FAIL b2b_gap%0d: got %0d expected 6", k, acc_cyc[k] - acc_cyc[k-1]); end
        end
        foreach (acc_code[k]) model_apply(acc_code[k]);
        for (int i = 0; i < NUM_TA; i++) begin
            total++;
            if (int'(dut.ta_state_q[i]) !== m_state[i]) begin bad++; $display("FAIL b2b_state%0d: got %0d expected %0d", i, dut.ta_state_q[i], m_state[i]); end
        end
        total++; if (flip_count !== 16'(m_flips)) begin bad++; $display("FAIL b2b_flip: got %0d expected %0d", flip_count, m_flips); end
    endtask

    task automatic test_reset_mid_update();
        int pulses;
        fb_valid = 1'b1;
        fb_code  = 8'hAA;
        @(negedge clk);
        fb_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_TA; i++) begin
            total++;
            if (int'(dut.ta_state_q[i]) !== RST_ST) begin bad++; $display("FAIL mid_state%0d: got %0d expected %0d", i, dut.ta_state_q[i], RST_ST); end
        end
        total++; if (incl !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_outputs: got inc=%b busy=%b done=%b expected 0000 0 0", incl, busy, done); end
        total++; if (flip_count !== 16'd0) begin bad++; $display("FAIL mid_flip: got %0d expected 0", flip_count); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (fb_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b expected 1", fb_ready); end
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_done: got %0d busy/done cycles expected 0", pulses); end
    endtask

    task automatic test_none_codes();
        int snap [NUM_TA];
        logic [7:0] code;
        int d;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NUM_TA; i++) begin
                snap[i] = m_state[i];
                code[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            end
            run_txn(code, d);
            total++; if (d !== 5) begin bad++; $display("FAIL none_done_t%0d: got %0d expected 5", t, d); end
            for (int i = 0; i < NUM_TA; i++) begin
                total++;
                if (int'(dut.ta_state_q[i]) !== snap[i]) begin bad++; $display("FAIL none_state_t%0d_%0d: got %0d expected %0d", t, i, dut.ta_state_q[i], snap[i]); end
            end
        end
    endtask

    task automatic test_random();
        int d;
        logic [7:0] code;
        for (int t = 0; t < 24; t++) begin
            code = 8'($urandom);
            run_txn(code, d);
            total++; if (d !== 5) begin bad++; $display("FAIL rnd_done_t%0d: got %0d expected 5", t, d); end
            total++; if (incl !== model_incl()) begin bad++; $display("FAIL rnd_incl_t%0d: got %b expected %b", t, incl, model_incl()); end
            total++; if (flip_count !== 16'(m_flips)) begin bad++; $display("FAIL rnd_flip_t%0d: got %0d expected %0d", t, flip_count, m_flips); end
            for (int i = 0; i < NUM_TA; i++) begin
                total++;
                if (int'(dut.ta_state_q[i]) !== m_state[i]) begin bad++; $display("FAIL rnd_state_t%0d_%0d: got %0d expected %0d", t, i, dut.ta_state_q[i], m_state[i]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_all_penalty();
        test_saturation();
        test_back_to_back();
        test_reset_mid_update();
        test_none_codes();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ta_bank.md
TA_BANK -- requirements
Module: ta_bank

Interface
REQ-001 Parameter NUM_TA, default 4: number of Tsetlin automata held (1..64).
REQ-002 Parameter STATE_BITS, default 4: width of each automaton state (2..8); states 0..2^STATE_BITS-1.
REQ-003 One clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fb_valid  input  1  feedback vector offered.
REQ-007 fb_ready  output  1  bank accepts feedback.
REQ-008 fb_code  input  2*NUM_TA  per-TA feedback; TA i uses bits [2i+1:2i].
REQ-009 include  output  NUM_TA  action per TA; bit i = MSB of state i.
REQ-010 busy  output  1  update sequence in progress.
REQ-011 done  output  1  one-cycle pulse when update sequence ends.
REQ-012 flip_count  output  16  action-flip counter (see Configuration).

Function
REQ-013 Feedback codes: 00 none, 01 reward, 10 penalty, 11 none (no state change).
REQ-014 Reward: state >= 2^(STATE_BITS-1) increments saturating at max; otherwise decrements saturating at 0.
REQ-015 Penalty: state >= 2^(STATE_BITS-1) decrements; otherwise increments; crossing the midpoint flips include.
REQ-016 FSM states IDLE, UPDATE, DONE; reset state IDLE.
REQ-017 IDLE: fb_ready=1; fb_valid&fb_ready captures fb_code into an internal register, clears index to 0, moves to UPDATE.
REQ-018 UPDATE: fb_ready=0, busy=1; one TA (index) updated per cycle; index increments; after index NUM_TA-1 move to DONE.
REQ-019 DONE: done=1 for exactly one cycle, fb_ready=0, busy=0; next state IDLE.
REQ-020 Latency: acceptance to done pulse is NUM_TA+1 cycles; next acceptance earliest NUM_TA+2 cycles after previous.
REQ-021 fb_valid while fb_ready=0 is ignored; fb_code changes after acceptance have no effect.
REQ-022 include updates the cycle after the corresponding TA is processed; unprocessed TAs hold state.
REQ-023 Saturation boundaries: reward at 0 or max holds; penalty never saturates (always crosses or moves toward centre).

Reset
REQ-024 rst_n low: every state = 2^(STATE_BITS-1)-1 (weak exclude), include=0, fb_ready=0 while asserted, busy=0, done=0, flip_count=0, index=0, FSM IDLE.
REQ-025 rst_n asserted mid-UPDATE aborts the sequence; partially applied updates are discarded by the reset values; no done pulse.
REQ-026 After rst_n deasserts, fb_ready=1 from the first clock edge.

Configuration
REQ-027 Macro TA_BANK_FLIPCNT_EN defined: flip_count increments by 1 on every TA update that changes that TA's include bit, saturating at 16'hFFFF.
REQ-028 Macro TA_BANK_FLIPCNT_EN undefined: no counter logic; flip_count tied to 0.

Structure
REQ-029 Package ta_pkg holds feedback code constants (FB_NONE, FB_REWARD, FB_PENALTY), FSM state enum, and flip counter width.
REQ-030 Sub-module ta_update: combinational next-state for one automaton (state, code -> next state, flip flag); instantiated once, shared by index mux.

Verification (NUM_TA=4, STATE_BITS=4, reset state 7)
REQ-031 Reset release, then idle -> all states 7, include=0000, fb_ready=1, flip_count=0.
REQ-032 fb_code all penalty (10101010) accepted -> states 8 after 4 UPDATE cycles, include=1111, done at cycle 5, flip_count=4 (with macro).
REQ-033 Reward on TA0 at state 15 and on TA1 at state 0 -> both hold; no flip; flip_count unchanged.
REQ-034 fb_valid held high continuously with changing fb_code -> second acceptance exactly 6 cycles after first; mid-sequence fb_code changes ignored.
REQ-035 rst_n pulsed low after 2 UPDATE cycles -> all states 7, no done pulse, FSM IDLE, fb_ready=1 after release.
REQ-036 Codes 11 and 00 on all TAs -> states unchanged, done still pulses after 5 cycles.
